// File: rtl/ssram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssram_pkg
// Purpose  : Shared burst constants and burst address helper for the SSRAM
//            responder and the bus controller model.
// Revision : 1.0  initial release
// ============================================================================
package ssram_pkg;

  localparam int BURST_LEN    = 4;
  localparam int READ_LATENCY = 2;
  localparam int BURST_W      = $clog2(BURST_LEN);

  // Word slot inside the aligned burst; the upper address bits never change,
  // so the burst wraps inside its 4-word group.
  function automatic logic [BURST_W-1:0] burst_addr(input logic [BURST_W-1:0] base,
                                                    input logic [BURST_W-1:0] cnt);
    return base + cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssram_emu_array.sv
`default_nettype none
// ============================================================================
// Module   : ssram_emu_array
// Purpose  : Single-port byte-enabled word RAM with registered read data.
// Revision : 1.0  initial release
// ============================================================================
module ssram_emu_array #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rd_en,
  input  logic [DW/8-1:0] wr_lanes,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wr_data,
  output logic [DW-1:0]   rd_data
);

  localparam int c_lanes = DW / 8;

  logic [DW-1:0] r_mem [2**AW];

  // No reset on the storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < c_lanes; i++) begin
      if (wr_lanes[i]) begin
        r_mem[addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
    if (rd_en) begin
      rd_data <= r_mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ssram_emu.sv
`default_nettype none
// ============================================================================
// Module   : ssram_emu
// Purpose  : Pipelined burst SSRAM responder: strobe decode, burst counter,
//            command register and two-stage read pipeline over a word array.
// Revision : 1.0  initial release
// ============================================================================
module ssram_emu
  import ssram_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   data_in,
  output logic [DW-1:0]   data_out,
  output logic            data_oe,
  input  logic            ce_n,
  input  logic            adsp_n,
  input  logic            adsc_n,
  input  logic            adv_n,
  input  logic            we_n,
  input  logic [DW/8-1:0] be_n,
  input  logic            gw_n,
  input  logic            oe_n
);

  localparam int c_lanes = DW / 8;

  logic               r_active;
  logic [AW-1:0]      r_base;
  logic [BURST_W-1:0] r_cnt;

  // Command issued at an edge is applied to the array one edge later, so the
  // single array port sees exactly one read or write per cycle.
  logic               r_cmd_rd;
  logic [c_lanes-1:0] r_cmd_lanes;
  logic [AW-1:0]      r_cmd_addr;
  logic [DW-1:0]      r_cmd_data;

  logic               r_v1;
  logic               r_v2;
  logic [DW-1:0]      w_rd_data;

  logic               w_is_wr;
  logic [c_lanes-1:0] w_wl;
  logic [AW-1:0]      w_ea;
  logic [AW-1:0]      w_ea_adv;
  logic [BURST_W-1:0] w_cnt_adv;

  logic               w_active_nxt;
  logic [AW-1:0]      w_base_nxt;
  logic [BURST_W-1:0] w_cnt_nxt;
  logic               w_iss_rd;
  logic               w_iss_wr;
  logic [AW-1:0]      w_iss_addr;

  assign w_is_wr   = ~we_n | ~gw_n;
  assign w_wl      = gw_n ? ~be_n : {c_lanes{1'b1}};
  assign w_cnt_adv = r_cnt + BURST_W'(1);
  assign w_ea      = {r_base[AW-1:BURST_W], burst_addr(r_base[BURST_W-1:0], r_cnt)};
  assign w_ea_adv  = {r_base[AW-1:BURST_W], burst_addr(r_base[BURST_W-1:0], w_cnt_adv)};

  always_comb begin
    w_active_nxt = r_active;
    w_base_nxt   = r_base;
    w_cnt_nxt    = r_cnt;
    w_iss_rd     = 1'b0;
    w_iss_wr     = 1'b0;
    w_iss_addr   = w_ea;
    if (!adsp_n && !ce_n) begin
      // ADSP start ignores we_n: always a read.
      w_active_nxt = 1'b1;
      w_base_nxt   = addr;
      w_cnt_nxt    = '0;
      w_iss_addr   = addr;
      w_iss_rd     = 1'b1;
    end else if (!adsp_n) begin
      w_active_nxt = r_active;
    end else if (!adsc_n && !ce_n) begin
      w_active_nxt = 1'b1;
      w_base_nxt   = addr;
      w_cnt_nxt    = '0;
      w_iss_addr   = addr;
      w_iss_wr     = w_is_wr;
      w_iss_rd     = ~w_is_wr;
    end else if (!adsc_n) begin
      w_active_nxt = 1'b0;
    end else if (r_active) begin
      if (!adv_n) begin
        w_cnt_nxt  = w_cnt_adv;
        w_iss_addr = w_ea_adv;
      end
      w_iss_wr = w_is_wr;
      w_iss_rd = ~w_is_wr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active    <= 1'b0;
      r_base      <= '0;
      r_cnt       <= '0;
      r_cmd_rd    <= 1'b0;
      r_cmd_lanes <= '0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      data_out    <= '0;
    end else begin
      r_active    <= w_active_nxt;
      r_base      <= w_base_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd_rd    <= w_iss_rd;
      r_cmd_lanes <= w_iss_wr ? w_wl : '0;
      r_v1        <= r_cmd_rd;
      r_v2        <= r_v1;
      if (r_v1) begin
        data_out <= w_rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_cmd_addr <= w_iss_addr;
    r_cmd_data <= data_in;
  end

  assign data_oe = r_v2 & ~oe_n;

  ssram_emu_array #(
    .AW (AW),
    .DW (DW)
  ) u_array (
    .clk      (clk),
    .rd_en    (r_cmd_rd),
    .wr_lanes (r_cmd_lanes),
    .addr     (r_cmd_addr),
    .wr_data  (r_cmd_data),
    .rd_data  (w_rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_ssram_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssram_emu
// Purpose  : Directed and randomized checks of ssram_emu against a queue-based
//            reference model of the strobe rules and read latency.
// Revision : 1.0  initial release
// ============================================================================
module tb_ssram_emu;
  import ssram_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          data_oe;
  logic          ce_n = 1'b0;
  logic          adsp_n = 1'b1;
  logic          adsc_n = 1'b1;
  logic          adv_n = 1'b1;
  logic          we_n = 1'b1;
  logic [3:0]    be_n = 4'hF;
  logic          gw_n = 1'b1;
  logic          oe_n = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    bit          v;
    logic [31:0] d;
  } iss_t;

  logic [31:0] m_mem [0:4095];
  int          m_base;
  int          m_cnt;
  bit          m_act;
  iss_t        m_q[$];
  logic [31:0] exp_do;
  bit          exp_v2;

  always #5 clk = ~clk;

  ssram_emu #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .ce_n     (ce_n),
    .adsp_n   (adsp_n),
    .adsc_n   (adsc_n),
    .adv_n    (adv_n),
    .we_n     (we_n),
    .be_n     (be_n),
    .gw_n     (gw_n),
    .oe_n     (oe_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act  = 0;
    m_base = 0;
    m_cnt  = 0;
    m_q.delete();
    exp_do = '0;
    exp_v2 = 0;
  endtask

  function automatic int model_ea(input int base, input int cnt);
    return (base & ~3) | ((base + cnt) & 3);
  endfunction

  task automatic model_write(input int a);
    logic [3:0] wl;
    wl = gw_n ? ~be_n : 4'hF;
    for (int i = 0; i < 4; i++)
      if (wl[i]) m_mem[a][i*8 +: 8] = data_in[i*8 +: 8];
  endtask

  // One clock edge of the responder as seen from the pins.
  task automatic model_edge();
    iss_t e;
    int   a;
    bit   wr;
    e.v = 0;
    e.d = '0;
    a   = 0;
    wr  = !we_n || !gw_n;
    if (!adsp_n && !ce_n) begin
      m_base = int'(addr); m_cnt = 0; m_act = 1;
      e.v = 1; e.d = m_mem[int'(addr)];
    end else if (!adsp_n) begin
      a = 0;
    end else if (!adsc_n && !ce_n) begin
      m_base = int'(addr); m_cnt = 0; m_act = 1;
      if (wr) model_write(int'(addr));
      else begin e.v = 1; e.d = m_mem[int'(addr)]; end
    end else if (!adsc_n) begin
      m_act = 0;
    end else if (m_act) begin
      if (!adv_n) m_cnt = (m_cnt + 1) % BURST_LEN;
      a = model_ea(m_base, m_cnt);
      if (wr) model_write(a);
      else begin e.v = 1; e.d = m_mem[a]; end
    end
    m_q.push_back(e);
    while (m_q.size() > READ_LATENCY + 1) void'(m_q.pop_front());
    if (m_q.size() == READ_LATENCY + 1 && m_q[0].v) begin
      exp_v2 = 1;
      exp_do = m_q[0].d;
    end else begin
      exp_v2 = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("data_out", data_out, exp_do);
    check("data_oe", 32'(data_oe), 32'(exp_v2 & ~oe_n));
  endtask

  task automatic drive(input bit sp, input bit sc, input bit ce, input bit we, input bit gw,
                       input bit av, input logic [3:0] be, input int a, input logic [31:0] d);
    adsp_n  = sp;
    adsc_n  = sc;
    ce_n    = ce;
    we_n    = we;
    gw_n    = gw;
    adv_n   = av;
    be_n    = be;
    addr    = AW'(a);
    data_in = d;
    step();
  endtask

  task automatic idle();                 drive(1, 1, 0, 1, 1, 1, 4'hF, 0, '0); endtask
  task automatic advance();              drive(1, 1, 0, 1, 1, 0, 4'hF, 0, '0); endtask
  task automatic desel();                drive(1, 0, 1, 1, 1, 1, 4'hF, 0, '0); endtask
  task automatic adsp_rd(input int a);   drive(0, 1, 0, 1, 1, 1, 4'hF, a, '0); endtask
  task automatic adsc_wr(input int a, input logic [31:0] d, input logic [3:0] be, input bit gw);
    drive(1, 0, 0, 0, gw, 1, be, a, d);
  endtask

  initial begin
    model_reset();
    #2 reset = 1'b1;
    #1;
    check("reset_data_out", data_out, 32'h0);
    check("reset_data_oe", 32'(data_oe), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Preload the address window used by all later traffic.
    for (int i = 0; i < 64; i++) adsc_wr(i, $urandom, 4'h0, 1'b1);
    desel();

    // ADSC write then ADSP read, latency 2.
    adsc_wr('h010, 32'hDEADBEEF, 4'h0, 1'b1);
    adsp_rd('h010);
    idle();
    idle();
    check("raw_data", data_out, 32'hDEADBEEF);
    check("raw_oe", 32'(data_oe), 32'h1);

    // Byte lanes and global write.
    adsc_wr('h020, 32'h11223344, 4'h0, 1'b1);
    adsc_wr('h020, 32'hAABBCCDD, 4'b1010, 1'b1);
    adsp_rd('h020);
    idle();
    idle();
    check("byte_lanes", data_out, 32'h11BB33DD);
    adsc_wr('h020, 32'hAABBCCDD, 4'b1111, 1'b0);
    adsp_rd('h020);
    idle();
    idle();
    check("global_write", data_out, 32'hAABBCCDD);

    // Burst wrap inside the aligned group, then deselect mid-burst.
    for (int i = 'h30; i <= 'h35; i++) adsc_wr(i, 32'(i), 4'h0, 1'b1);
    adsp_rd('h032);
    advance();
    advance();
    check("wrap_beat0", data_out, 32'h32);
    advance();
    check("wrap_beat1", data_out, 32'h33);
    desel();
    check("wrap_beat2", data_out, 32'h30);
    idle();
    check("wrap_beat3", data_out, 32'h31);
    idle();
    check("desel_oe_off", 32'(data_oe), 32'h0);

    // ADSP while deselected starts nothing.
    idle();
    drive(0, 1, 1, 1, 1, 1, 4'hF, 'h010, '0);
    idle();
    idle();
    check("adsp_desel_oe", 32'(data_oe), 32'h0);

    // ADSP with we_n low is still a read.
    drive(0, 1, 0, 0, 1, 1, 4'h0, 'h010, 32'h12345678);
    idle();
    idle();
    check("adsp_we_read", data_out, 32'hDEADBEEF);
    adsp_rd('h010);
    idle();
    idle();
    check("adsp_we_nowrite", data_out, 32'hDEADBEEF);

    // oe_n gates the output asynchronously while the burst keeps running.
    adsp_rd('h030);
    advance();
    advance();
    check("oe_beat0", data_out, 32'h30);
    check("oe_on", 32'(data_oe), 32'h1);
    #3 oe_n = 1'b1;
    #1;
    check("oe_async_off", 32'(data_oe), 32'h0);
    advance();
    check("oe_beat1", data_out, 32'h31);
    oe_n = 1'b0;
    advance();
    check("oe_beat2", data_out, 32'h32);

    // Asynchronous reset in the middle of a read burst.
    adsp_rd('h030);
    advance();
    advance();
    check("rst_pre_data", data_out, 32'h30);
    #2 reset = 1'b1;
    #1;
    check("rst_async_data", data_out, 32'h0);
    check("rst_async_oe", 32'(data_oe), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
    adsp_rd('h033);
    advance();
    advance();
    check("rst_mem_keep0", data_out, 32'h33);
    advance();
    check("rst_mem_keep1", data_out, 32'h30);

    // Randomized traffic over the preloaded window.
    for (int n = 0; n < 500; n++) begin
      int r;
      r = int'($urandom_range(0, 15));
      oe_n = ($urandom_range(0, 7) == 0);
      drive(!(r < 2), !(r >= 2 && r < 5), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) != 0),
            ($urandom_range(0, 1) == 0), 4'($urandom), int'($urandom_range(0, 63)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
